multi_cycle_core: RTL and testbench
===================================

// Module: multi_cycle_core
// PURPOSE
//  Multi-cycle MIPS-subset CPU; successor to the single-cycle top. One shared
//  ALU and one unified, handshaked memory port replace the separate IM/DM and
//  adders. A Moore FSM sequences FETCH/DECODE/EXEC/MEM/WB, so each instruction
//  takes 3-5 states plus memory wait cycles. Sits between the testbench/top
//  and one external memory model.
// PARAMETERS
//  RESET_PC  32'h0  PC value loaded on Reset.
//  RF_DEPTH  32     Register count (8/16/32); index = rs/rt/rd mod RF_DEPTH; r0 reads 0.
//  MEM_TMO   16     Max wait cycles for mem_ack; exceeding it enters HALT.
// PORTS
//  Clock      in   1   rising-edge clock.
//  Reset      in   1   synchronous, active-high reset.
//  mem_req    out  1   memory request; held until mem_ack.
//  mem_we     out  1   1 = write (sw), 0 = read (fetch/lw).
//  mem_addr   out  32  byte address, word aligned ([1:0]=0).
//  mem_wdata  out  32  store data.
//  mem_rdata  in   32  read data, valid in the mem_ack cycle.
//  mem_ack    in   1   transfer completes in the cycle req&ack are both 1.
//  halt       out  1   core stopped (illegal opcode or timeout); sticky.
//  pc_out     out  32  current PC, for debug.
// BEHAVIOUR
//  Reset: state=FETCH, PC=RESET_PC, all RF=0, mem_req=0, mem_we=0,
//   mem_addr=0, mem_wdata=0, halt=0, IR=0. Reset wins over every other event,
//   incl. an in-flight request: mem_req is 0 the cycle after Reset is sampled.
//  Handshake: mem_addr/mem_we/mem_wdata stable while mem_req=1; mem_ack with
//   mem_req=0 is ignored. One transaction outstanding at most.
//  FETCH: req read @PC; on ack IR<=rdata, PC<=PC+4 (32-bit wrap) -> DECODE.
//  DECODE: A<=RF[rs], B<=RF[rt], imm=sign-ext(IR[15:0]) -> EXEC.
//   Illegal opcode/funct -> HALT.
//  EXEC:
//   R-type (op 0): funct 20 add,22 sub,24 and,25 or,2A slt (signed) -> WB.
//   addi (08): A+imm -> WB. lw(23)/sw(2B): addr=A+imm -> MEM.
//   beq (04): if A==B PC<=PC+(imm<<2) -> FETCH. j (02):
//   PC<={PC[31:28],IR[25:0],2'b00} -> FETCH.
//   All add/sub modulo 2^32; no overflow traps.
//  MEM: lw read / sw write at addr; on ack: lw -> WB, sw -> FETCH.
//  WB: R-type writes rd, lw/addi write rt; writes to r0 discarded -> FETCH.
//  Latency (zero-wait memory, ack same cycle as req): R/addi 4 cyc,
//   lw 5, sw 4, beq/j 3.
//  Timeout: wait counter resets on each new request; MEM_TMO cycles without
//   ack -> drop req, HALT.
//  HALT: absorbing until Reset; halt=1, mem_req=0, no RF/PC updates.
//  Misaligned lw/sw address: [1:0] forced to 0 (no trap).
// CONFIGURATION
//  MC_BNE_EN defined: opcode 05 (bne) legal; if A!=B branch as beq, 3 cycles.
//  MC_BNE_EN undefined: opcode 05 illegal -> HALT in DECODE.
// TESTING
//  1 Reset with RESET_PC=32'h100 -> first mem_req addr 0x100, we=0, halt=0.
//  2 addi r1,r0,5; addi r2,r0,7; add r3,r1,r2; sw r3,0x40(r0) -> write
//    addr 0x40 data 12; cycle count 4+4+4+4=16 with zero-wait memory.
//  3 lw with mem_ack delayed 3 cycles -> addr/we stable throughout, rt
//    loaded, total 8 cycles; ack pulse while req=0 has no effect.
//  4 beq r0,r0,-1 at 0x8 -> next fetch at 0x8; j 0x40 -> fetch at 0x100.
//  5 Opcode 3F, or no ack for MEM_TMO=16 cycles -> halt=1, req=0 held;
//    Reset asserted -> halt=0, fetch at RESET_PC.
//  6 bne r1,r2 with r1!=r2: with MC_BNE_EN taken; without it halt=1.

Source files
------------

// File: rtl/multi_cycle_core.sv
// Multi-cycle MIPS-subset core: one shared ALU, one handshaked memory port, Moore FSM.
// Optional feature macro: MC_BNE_EN (adds bne, opcode 05).
module multi_cycle_core #(
  parameter logic [31:0] RESET_PC = 32'h0,
  parameter int          RF_DEPTH = 32,
  parameter int          MEM_TMO  = 16
) (
  input  logic        Clock,
  input  logic        Reset,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack,
  output logic        halt,
  output logic [31:0] pc_out,
  output logic [2:0]  dbg_state_o
);

  localparam int RFW = $clog2(RF_DEPTH);

  localparam logic [5:0] OP_R    = 6'h00;
  localparam logic [5:0] OP_J    = 6'h02;
  localparam logic [5:0] OP_BEQ  = 6'h04;
  localparam logic [5:0] OP_BNE  = 6'h05;
  localparam logic [5:0] OP_ADDI = 6'h08;
  localparam logic [5:0] OP_LW   = 6'h23;
  localparam logic [5:0] OP_SW   = 6'h2B;

  localparam logic [5:0] F_ADD = 6'h20;
  localparam logic [5:0] F_SUB = 6'h22;
  localparam logic [5:0] F_AND = 6'h24;
  localparam logic [5:0] F_OR  = 6'h25;
  localparam logic [5:0] F_SLT = 6'h2A;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_t;

  typedef enum logic [2:0] {
    ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT
  } alu_op_t;

  // Memory handshake: the core holds mem_req and its addr/we/wdata constant
  // until the cycle where mem_req && mem_ack; an ack without req is ignored.

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] ir_q, ir_d;
  logic [31:0] a_q, a_d;
  logic [31:0] b_q, b_d;
  logic [31:0] imm_q, imm_d;
  logic [31:0] alu_q, alu_d;
  logic [31:0] mdr_q, mdr_d;
  logic        req_q, req_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [15:0] tmo_q, tmo_d;
  logic [31:0] rf_q [RF_DEPTH];

  logic           rf_we;
  logic [RFW-1:0] rf_wa;
  logic [31:0]    rf_wd;
  logic           issue_fetch;

  logic [5:0]     op, funct;
  logic [RFW-1:0] rs_idx, rt_idx, rd_idx;
  logic           legal, take;

  alu_op_t     alu_op;
  logic [31:0] alu_a, alu_b, alu_y;

  assign op     = ir_q[31:26];
  assign funct  = ir_q[5:0];
  assign rs_idx = ir_q[21 +: RFW];
  assign rt_idx = ir_q[16 +: RFW];
  assign rd_idx = ir_q[11 +: RFW];

  always_comb begin
    legal = 1'b0;
    case (op)
      OP_R:                                 legal = funct inside {F_ADD, F_SUB, F_AND, F_OR, F_SLT};
      OP_J, OP_BEQ, OP_ADDI, OP_LW, OP_SW:  legal = 1'b1;
`ifdef MC_BNE_EN
      OP_BNE:                               legal = 1'b1;
`endif
      default:                              legal = 1'b0;
    endcase
  end

`ifdef MC_BNE_EN
  assign take = ((op == OP_BEQ) && (a_q == b_q)) || ((op == OP_BNE) && (a_q != b_q));
`else
  assign take = (op == OP_BEQ) && (a_q == b_q);
`endif

  // The single ALU computes PC+4 in FETCH and the data/branch result in EXEC.
  always_comb begin
    alu_a  = a_q;
    alu_b  = b_q;
    alu_op = ALU_ADD;
    if (state_q == S_FETCH) begin
      alu_a = pc_q;
      alu_b = 32'd4;
    end else if (op == OP_BEQ || op == OP_BNE) begin
      alu_a = pc_q;
      alu_b = {imm_q[29:0], 2'b00};
    end else if (op != OP_R) begin
      alu_b = imm_q;
    end else begin
      case (funct)
        F_SUB:   alu_op = ALU_SUB;
        F_AND:   alu_op = ALU_AND;
        F_OR:    alu_op = ALU_OR;
        F_SLT:   alu_op = ALU_SLT;
        default: alu_op = ALU_ADD;
      endcase
    end
  end

  always_comb begin
    case (alu_op)
      ALU_SUB: alu_y = alu_a - alu_b;
      ALU_AND: alu_y = alu_a & alu_b;
      ALU_OR:  alu_y = alu_a | alu_b;
      ALU_SLT: alu_y = ($signed(alu_a) < $signed(alu_b)) ? 32'd1 : 32'd0;
      default: alu_y = alu_a + alu_b;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    ir_d        = ir_q;
    a_d         = a_q;
    b_d         = b_q;
    imm_d       = imm_q;
    alu_d       = alu_q;
    mdr_d       = mdr_q;
    req_d       = req_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    tmo_d       = tmo_q;
    rf_we       = 1'b0;
    rf_wa       = rt_idx;
    rf_wd       = alu_q;
    issue_fetch = 1'b0;

    case (state_q)
      S_FETCH: begin
        if (!req_q) begin
          issue_fetch = 1'b1;
        end else if (mem_ack) begin
          req_d   = 1'b0;
          ir_d    = mem_rdata;
          pc_d    = alu_y;
          state_d = S_DECODE;
        end else if (tmo_q == 16'(MEM_TMO - 1)) begin
          req_d   = 1'b0;
          state_d = S_HALT;
        end else begin
          tmo_d = tmo_q + 16'd1;
        end
      end
      S_DECODE: begin
        a_d     = (rs_idx == '0) ? 32'd0 : rf_q[rs_idx];
        b_d     = (rt_idx == '0) ? 32'd0 : rf_q[rt_idx];
        imm_d   = {{16{ir_q[15]}}, ir_q[15:0]};
        state_d = legal ? S_EXEC : S_HALT;
      end
      S_EXEC: begin
        alu_d = alu_y;
        case (op)
          OP_R, OP_ADDI: state_d = S_WB;
          OP_LW, OP_SW: begin
            // Misaligned data addresses are silently word-aligned.
            req_d   = 1'b1;
            we_d    = (op == OP_SW);
            addr_d  = {alu_y[31:2], 2'b00};
            wdata_d = b_q;
            tmo_d   = 16'd0;
            state_d = S_MEM;
          end
          OP_J: begin
            pc_d        = {pc_q[31:28], ir_q[25:0], 2'b00};
            issue_fetch = 1'b1;
            state_d     = S_FETCH;
          end
          OP_BEQ, OP_BNE: begin
            if (take) pc_d = alu_y;
            issue_fetch = 1'b1;
            state_d     = S_FETCH;
          end
          default: state_d = S_HALT;
        endcase
      end
      S_MEM: begin
        if (mem_ack) begin
          req_d = 1'b0;
          if (we_q) begin
            issue_fetch = 1'b1;
            state_d     = S_FETCH;
          end else begin
            mdr_d   = mem_rdata;
            state_d = S_WB;
          end
        end else if (tmo_q == 16'(MEM_TMO - 1)) begin
          req_d   = 1'b0;
          state_d = S_HALT;
        end else begin
          tmo_d = tmo_q + 16'd1;
        end
      end
      S_WB: begin
        rf_we       = 1'b1;
        rf_wa       = (op == OP_R) ? rd_idx : rt_idx;
        rf_wd       = (op == OP_LW) ? mdr_q : alu_q;
        issue_fetch = 1'b1;
        state_d     = S_FETCH;
      end
      S_HALT: req_d = 1'b0;
      default: state_d = S_HALT;
    endcase

    // A fetch request goes out with the PC already updated for this cycle.
    if (issue_fetch) begin
      req_d  = 1'b1;
      we_d   = 1'b0;
      addr_d = pc_d;
      tmo_d  = 16'd0;
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q <= S_FETCH;
      pc_q    <= RESET_PC;
      ir_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      imm_q   <= '0;
      alu_q   <= '0;
      mdr_q   <= '0;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      tmo_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      a_q     <= a_d;
      b_q     <= b_d;
      imm_q   <= imm_d;
      alu_q   <= alu_d;
      mdr_q   <= mdr_d;
      req_q   <= req_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      tmo_q   <= tmo_d;
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      for (int i = 0; i < RF_DEPTH; i++) rf_q[i] <= '0;
    end else if (rf_we && rf_wa != '0) begin
      rf_q[rf_wa] <= rf_wd;
    end
  end

  assign mem_req     = req_q;
  assign mem_we      = we_q;
  assign mem_addr    = addr_q;
  assign mem_wdata   = wdata_q;
  assign halt        = (state_q == S_HALT);
  assign pc_out      = pc_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_multi_cycle_core.sv
// Bench for multi_cycle_core: memory responder, transaction scoreboard, directed programs.
module tb_multi_cycle_core;

  localparam logic [31:0] RPC = 32'h100;

  logic        Clock;
  logic        Reset;
  logic        mem_req, mem_we, mem_ack, halt;
  logic [31:0] mem_addr, mem_wdata, mem_rdata, pc_out;
  logic [2:0]  dbg_state;

  multi_cycle_core #(.RESET_PC(RPC), .RF_DEPTH(32), .MEM_TMO(16)) dut (
    .Clock(Clock), .Reset(Reset),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .halt(halt), .pc_out(pc_out), .dbg_state_o(dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  int cyc = 0;
  always @(posedge Clock) cyc <= cyc + 1;

  // ---------------- memory model ----------------
  logic [31:0] mem [1024];
  logic [31:0] slow_addr;
  int          slow_wait;
  bit          slow_en, stray_en;
  int          wait_cnt;

  initial begin
    mem_ack = 1'b0; mem_rdata = '0; wait_cnt = 0;
    forever begin
      @(negedge Clock);
      if (mem_req) begin
        if (!(slow_en && mem_addr == slow_addr) || wait_cnt >= slow_wait) begin
          mem_ack  = 1'b1;
          wait_cnt = 0;
          if (mem_we) mem[mem_addr[11:2]] = mem_wdata;
          else        mem_rdata = mem[mem_addr[11:2]];
        end else begin
          mem_ack  = 1'b0;
          wait_cnt = wait_cnt + 1;
        end
      end else begin
        mem_ack   = stray_en;
        mem_rdata = 32'hBAD0BAD0;
        wait_cnt  = 0;
      end
    end
  end

  // ---------------- scoreboard ----------------
  // item = {gap[7:0], we, addr[31:0], data[31:0]}; gap 0 means "do not check".
  logic [72:0] exp_q[$];
  int          n_checks = 0;
  int          n_fail = 0;
  bit          mon_en = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push_fetch(input logic [31:0] addr, input logic [7:0] gap);
    exp_q.push_back({gap, 1'b0, addr, 32'h0});
  endtask

  task automatic push_read(input logic [31:0] addr, input logic [7:0] gap);
    exp_q.push_back({gap, 1'b0, addr, 32'h0});
  endtask

  task automatic push_store(input logic [31:0] addr, input logic [31:0] data, input logic [7:0] gap);
    exp_q.push_back({gap, 1'b1, addr, data});
  endtask

  logic [72:0] item;
  logic [64:0] held;
  bit          in_wait = 0;
  int          last_cyc = 0;

  initial begin
    forever begin
      @(negedge Clock); #1;
      if (Reset || !mon_en) begin
        in_wait = 0;
      end else if (mem_req) begin
        if (in_wait) begin
          check("stable_we",    {31'b0, mem_we}, {31'b0, held[64]});
          check("stable_addr",  mem_addr,  held[63:32]);
          check("stable_wdata", mem_wdata, held[31:0]);
        end
        if (mem_ack) begin
          in_wait = 0;
          if (exp_q.size() == 0) begin
            n_checks++; n_fail++;
            $display("FAIL unexpected_txn: got we=%0b addr=%h, expected none", mem_we, mem_addr);
          end else begin
            item = exp_q.pop_front();
            check("txn_we",   {31'b0, mem_we}, {31'b0, item[64]});
            check("txn_addr", mem_addr, item[63:32]);
            if (item[64]) check("txn_wdata", mem_wdata, item[31:0]);
            if (item[72:65] != 8'd0) check("txn_gap", 32'(cyc - last_cyc), {24'b0, item[72:65]});
          end
          last_cyc = cyc;
        end else if (!in_wait) begin
          in_wait = 1;
          held = {mem_we, mem_addr, mem_wdata};
        end
      end else begin
        in_wait = 0;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic start_reset();
    @(negedge Clock);
    Reset = 1'b1;
    mon_en = 0;
    @(negedge Clock);
    for (int i = 0; i < 1024; i++) mem[i] = '0;
    slow_en = 0; stray_en = 0; slow_wait = 0; slow_addr = '0;
  endtask

  task automatic finish_reset();
    @(negedge Clock);
    check("rst_req",   {31'b0, mem_req}, 32'd0);
    check("rst_we",    {31'b0, mem_we},  32'd0);
    check("rst_addr",  mem_addr,  32'd0);
    check("rst_wdata", mem_wdata, 32'd0);
    check("rst_halt",  {31'b0, halt}, 32'd0);
    check("rst_pc",    pc_out, RPC);
    Reset = 1'b0;
    exp_q.delete();
    mon_en = 1;
  endtask

  task automatic run_until_empty(input int max_cyc);
    int n = 0;
    while (exp_q.size() != 0 && n < max_cyc) begin
      @(posedge Clock);
      n++;
    end
    if (exp_q.size() != 0) begin
      n_checks++; n_fail++;
      $display("FAIL scoreboard_timeout: got %0d items left, expected 0", exp_q.size());
      exp_q.delete();
    end
    mon_en = 0;
  endtask

  task automatic wait_halt(input int max_cyc);
    int n = 0;
    while (halt !== 1'b1 && n < max_cyc) begin
      @(negedge Clock);
      n++;
    end
    check("halt_set", {31'b0, halt}, 32'd1);
    repeat (4) begin
      @(negedge Clock);
      check("halt_req_low", {31'b0, mem_req}, 32'd0);
      check("halt_sticky",  {31'b0, halt}, 32'd1);
    end
  endtask

  // ---------------- directed tests ----------------
  int req_cycles;

  initial begin
    Reset = 1'b1;

    // ALU ops, addi, sw (incl. misaligned and r0 write), zero-wait latency.
    start_reset();
    mem[32'h100 >> 2] = 32'h20010005;  // addi r1,r0,5
    mem[32'h104 >> 2] = 32'h20020007;  // addi r2,r0,7
    mem[32'h108 >> 2] = 32'h00221820;  // add  r3,r1,r2
    mem[32'h10C >> 2] = 32'hAC030040;  // sw   r3,0x40(r0)
    mem[32'h110 >> 2] = 32'h00222022;  // sub  r4,r1,r2
    mem[32'h114 >> 2] = 32'h0081282A;  // slt  r5,r4,r1
    mem[32'h118 >> 2] = 32'h00223024;  // and  r6,r1,r2
    mem[32'h11C >> 2] = 32'h00223825;  // or   r7,r1,r2
    mem[32'h120 >> 2] = 32'hAC040044;  // sw   r4,0x44
    mem[32'h124 >> 2] = 32'hAC050048;  // sw   r5,0x48
    mem[32'h128 >> 2] = 32'hAC06004C;  // sw   r6,0x4C
    mem[32'h12C >> 2] = 32'hAC070050;  // sw   r7,0x50
    mem[32'h130 >> 2] = 32'hAC010057;  // sw   r1,0x57 -> 0x54
    mem[32'h134 >> 2] = 32'h2028FFFA;  // addi r8,r1,-6
    mem[32'h138 >> 2] = 32'hAC080058;  // sw   r8,0x58
    mem[32'h13C >> 2] = 32'h20000009;  // addi r0,r0,9
    mem[32'h140 >> 2] = 32'hAC00005C;  // sw   r0,0x5C
    finish_reset();
    push_fetch(32'h100, 0); push_fetch(32'h104, 4); push_fetch(32'h108, 4);
    push_fetch(32'h10C, 4); push_store(32'h40, 32'd12, 3); push_fetch(32'h110, 1);
    push_fetch(32'h114, 4); push_fetch(32'h118, 4); push_fetch(32'h11C, 4);
    push_fetch(32'h120, 4); push_store(32'h44, 32'hFFFFFFFE, 3);
    push_fetch(32'h124, 1); push_store(32'h48, 32'd1, 3);
    push_fetch(32'h128, 1); push_store(32'h4C, 32'd5, 3);
    push_fetch(32'h12C, 1); push_store(32'h50, 32'd7, 3);
    push_fetch(32'h130, 1); push_store(32'h54, 32'd5, 3);
    push_fetch(32'h134, 1); push_fetch(32'h138, 4); push_store(32'h58, 32'hFFFFFFFF, 3);
    push_fetch(32'h13C, 1); push_fetch(32'h140, 4); push_store(32'h5C, 32'd0, 3);
    push_fetch(32'h144, 1);
    run_until_empty(300);

    // lw with 3 wait cycles and stray acks while idle.
    start_reset();
    mem[32'h100 >> 2] = 32'h8C040080;  // lw r4,0x80(r0)
    mem[32'h104 >> 2] = 32'hAC040044;  // sw r4,0x44(r0)
    mem[32'h80 >> 2]  = 32'hDEADBEEF;
    slow_en = 1; slow_addr = 32'h80; slow_wait = 3; stray_en = 1;
    finish_reset();
    push_fetch(32'h100, 0); push_read(32'h80, 6); push_fetch(32'h104, 2);
    push_store(32'h44, 32'hDEADBEEF, 3); push_fetch(32'h108, 1);
    run_until_empty(100);

    // beq r0,r0,-1 loops onto itself.
    start_reset();
    mem[32'h100 >> 2] = 32'h1000FFFF;
    finish_reset();
    push_fetch(32'h100, 0); push_fetch(32'h100, 3); push_fetch(32'h100, 3);
    run_until_empty(50);

    // beq not taken, then j 0x40 -> 0x100.
    start_reset();
    mem[32'h100 >> 2] = 32'h20010005;  // addi r1,r0,5
    mem[32'h104 >> 2] = 32'h10200005;  // beq  r1,r0,+5
    mem[32'h108 >> 2] = 32'h08000040;  // j    0x40
    finish_reset();
    push_fetch(32'h100, 0); push_fetch(32'h104, 4); push_fetch(32'h108, 3);
    push_fetch(32'h100, 3); push_fetch(32'h104, 4);
    run_until_empty(80);

    // Illegal opcode 3F halts; reset recovers.
    start_reset();
    mem[32'h100 >> 2] = 32'hFC000000;
    finish_reset();
    push_fetch(32'h100, 0);
    run_until_empty(20);
    wait_halt(10);
    start_reset();
    mem[32'h100 >> 2] = 32'hFC000000;
    finish_reset();
    push_fetch(32'h100, 0);
    run_until_empty(20);

    // Reset during an outstanding request, then a full data timeout.
    start_reset();
    mem[32'h100 >> 2] = 32'h8C010080;  // lw r1,0x80(r0)
    slow_en = 1; slow_addr = 32'h80; slow_wait = 1000;
    finish_reset();
    push_fetch(32'h100, 0);
    run_until_empty(20);
    repeat (6) @(negedge Clock);
    check("wait_req",  {31'b0, mem_req}, 32'd1);
    check("wait_addr", mem_addr, 32'h80);
    Reset = 1'b1;
    @(negedge Clock);
    check("rst_drops_req", {31'b0, mem_req}, 32'd0);
    Reset = 1'b0;
    @(negedge Clock);
    start_reset();
    mem[32'h100 >> 2] = 32'h8C010080;
    slow_en = 1; slow_addr = 32'h80; slow_wait = 1000;
    finish_reset();
    push_fetch(32'h100, 0);
    run_until_empty(20);
    req_cycles = 0;
    for (int n = 0; n < 40 && halt !== 1'b1; n++) begin
      @(negedge Clock);
      if (mem_req === 1'b1) req_cycles++;
    end
    check("tmo_req_cycles", 32'(req_cycles), 32'd16);
    wait_halt(2);
    start_reset();
    mem[32'h100 >> 2] = 32'h8C010080;
    finish_reset();
    push_fetch(32'h100, 0); push_read(32'h80, 3); push_fetch(32'h104, 2);
    run_until_empty(40);

    // bne r1,r2 with r1 != r2.
    start_reset();
    mem[32'h100 >> 2] = 32'h20010005;  // addi r1,r0,5
    mem[32'h104 >> 2] = 32'h20020007;  // addi r2,r0,7
    mem[32'h108 >> 2] = 32'h14220002;  // bne  r1,r2,+2 -> 0x114
    finish_reset();
    push_fetch(32'h100, 0); push_fetch(32'h104, 4); push_fetch(32'h108, 4);
`ifdef MC_BNE_EN
    push_fetch(32'h114, 3);
    run_until_empty(60);
`else
    run_until_empty(60);
    wait_halt(10);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no end of test, expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
